ocs_4x4_cfg_ctrl: RTL and testbench
===================================

Name: ocs_4x4_cfg_ctrl

Overview:
- Configuration controller that drives the 6-bit grant word of the 4x4 optical circuit switch fabric, which is built from six 2x2 bar/cross elements.
- Accepts a requested input-to-output permutation over a valid/ready handshake and checks that it is a legal permutation.
- Searches for the lowest grant code the fabric realizes as that permutation, then applies it.
- Blanks the data path for a reconfiguration guard time and reports completion or error.

Parameters:
- P_BAR, 1'b0: grant value for the bar setting (out0=in0, out1=in1).
- P_CROSS, 1'b1: grant value for the cross setting (out0=in1, out1=in0).
- P_GUARD_CYCLES, 16: optical settle time in cycles; must be at least 1.
- P_GUARD_W, 8: width of the guard counter.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous reset, active-high.
- i_req_valid  in  1  request valid.
- o_req_ready  out  1  high only in IDLE.
- i_req_dest  in  8  destination per input port; bits [2i+1:2i] are the output port for input i.
- o_grant  out  6  registered grant; bit j controls element j.
- o_path_en  out  1  data path enable; low while the fabric is unsettled.
- o_cfg_done  out  1  one-cycle completion pulse.
- o_cfg_err  out  1  valid with o_cfg_done; 1 means the request was rejected.
- o_active_dest  out  8  permutation currently applied.
- o_busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Interface: one clock (i_clk); reset (i_rst) is synchronous and active-high.
- Fabric topology, with each element taking {in1,in0} and producing {out1,out0}:
  - e0: in0=port0, in1=e1.out0.
  - e1: in0=port1, in1=e3.out0.
  - e3: in0=port2, in1=port3.
  - e4: in0=e1.out1, in1=e3.out1.
  - e2: in0=e0.out1, in1=e4.out0.
  - e5: in0=e2.out1, in1=e4.out1.
  - Fabric outputs: out0=e0.out0, out1=e2.out0, out2=e5.out0, out3=e5.out1.
- Reset values: o_grant=6'h00, o_path_en=0, o_cfg_done=0, o_cfg_err=0, o_active_dest=8'hE4, o_busy=0, state=IDLE.
- Reset also clears the internal active_valid flag. Reset mid-operation discards the latched request and any partial search.
- IDLE:
  - o_req_ready=1.
  - On i_req_valid && o_req_ready, latch i_req_dest and go to CHECK.
  - Requests arriving in any other state are ignored and not queued.
- CHECK (1 cycle):
  - If the four 2-bit fields are not pairwise distinct: go to DONE with err=1; o_grant, o_path_en and o_active_dest are unchanged.
  - Else if active_valid && dest == o_active_dest: go to DONE with err=0 and no fabric change.
  - Else: code=0, go to SEARCH.
- SEARCH (1 code per cycle):
  - Each cycle, model the fabric for the current code.
  - On match: o_grant<=code, o_path_en<=0, o_active_dest<=dest, active_valid<=1, guard counter loaded, go to GUARD.
  - On no match: code+1.
  - If code 63 does not match: go to DONE with err=1 and nothing changed.
- GUARD: hold for P_GUARD_CYCLES cycles, then o_path_en<=1 and go to DONE.
- DONE (1 cycle): o_cfg_done=1 with o_cfg_err per the path taken, then return to IDLE.
- Latency, with acceptance at cycle T and matching code k:
  - o_grant changes at T+3+k.
  - o_cfg_done and the rising edge of o_path_en occur at T+3+k+P_GUARD_CYCLES.
  - Reject or same-map: o_cfg_done at T+2.
- o_grant changes only on a SEARCH match or on reset. It never glitches, and it is never the code that failed.

Decomposition:
- Shared package ocs_ctrl_pkg holds:
  - FSM state encoding (IDLE, CHECK, SEARCH, GUARD, DONE).
  - BAR/CROSS constants.
  - Identity map constant 8'hE4.
- One combinational sub-module, ocs_4x4_route_model: 6-bit code in, 8-bit realized dest map out, implementing exactly the topology above. The verification reference model shares the same algorithm.

Test Plan:
- Reset, then request 8'hE4 (identity) with P_GUARD_CYCLES=16 -> code 0 matches, o_grant=6'h00, o_path_en low 16 cycles; done at T+19 with err=0.
- Request 8'hB4 (0->0, 1->1, 2->3, 3->2) -> o_grant=6'h08 at T+11 (k=8); done at T+27 with err=0; o_active_dest=8'hB4.
- Repeat 8'hB4 -> done at T+2, err=0, o_grant and o_path_en untouched.
- Request 8'h00 (duplicate destinations) -> done at T+2, err=1, o_grant stays 6'h08, o_path_en stays 1.
- Assert i_req_valid during SEARCH, then i_rst at GUARD cycle 5 -> second request ignored; after reset all outputs return to reset values and o_req_ready=1.
- Sweep all 24 permutations -> each o_grant equals the lowest code found by the reference model, the route model of o_grant equals the request, and latency matches the formula.

Source files
------------

// File: rtl/ocs_ctrl_pkg.sv
// Shared types and constants for the 4x4 optical circuit switch controller.
package ocs_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_SEARCH,
        ST_GUARD,
        ST_DONE
    } ocs_state_e;

    localparam logic       BAR          = 1'b0;
    localparam logic       CROSS        = 1'b1;
    localparam logic [7:0] IDENTITY_MAP = 8'hE4;
    localparam logic [5:0] LAST_CODE    = 6'h3F;

    // A map is legal when the four 2-bit destination fields are pairwise distinct.
    function automatic logic perm_legal(input logic [7:0] d);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 4; i++)
            for (int j = i + 1; j < 4; j++)
                if (d[2*i +: 2] == d[2*j +: 2]) ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/ocs_4x4_route_model.sv
// Combinational model of the six-element fabric: grant code in, realized
// destination map out (bits [2i+1:2i] = output port reached by input i).
module ocs_4x4_route_model
    import ocs_ctrl_pkg::*;
#(
    parameter logic P_BAR   = BAR,
    parameter logic P_CROSS = CROSS
) (
    input  logic [5:0] code,
    output logic [7:0] dest
);

    // Wires carry the label of the input port riding on them; result is {out1,out0}.
    function automatic logic [3:0] elem(input logic g, input logic [1:0] in1,
                                        input logic [1:0] in0);
        if (g == P_BAR)        return {in1, in0};
        else if (g == P_CROSS) return {in0, in1};
        else                   return {in1, in0};
    endfunction

    logic [1:0] e0_0, e0_1, e1_0, e1_1, e2_0, e2_1;
    logic [1:0] e3_0, e3_1, e4_0, e4_1, e5_0, e5_1;

    // Propagate port labels through the fabric, then invert output->input into input->output.
    always_comb begin
        {e3_1, e3_0} = elem(code[3], 2'd3, 2'd2);
        {e1_1, e1_0} = elem(code[1], e3_0, 2'd1);
        {e0_1, e0_0} = elem(code[0], e1_0, 2'd0);
        {e4_1, e4_0} = elem(code[4], e3_1, e1_1);
        {e2_1, e2_0} = elem(code[2], e4_0, e0_1);
        {e5_1, e5_0} = elem(code[5], e4_1, e2_1);
        dest = '0;
        dest[{e0_0, 1'b0} +: 2] = 2'd0;
        dest[{e2_0, 1'b0} +: 2] = 2'd1;
        dest[{e5_0, 1'b0} +: 2] = 2'd2;
        dest[{e5_1, 1'b0} +: 2] = 2'd3;
    end

endmodule

// File: rtl/ocs_4x4_cfg_ctrl.sv
// Configuration controller: validates a requested permutation, searches for
// the lowest grant code realizing it, applies it and blanks the path for the
// optical settle time.
module ocs_4x4_cfg_ctrl
    import ocs_ctrl_pkg::*;
#(
    parameter logic P_BAR          = BAR,
    parameter logic P_CROSS        = CROSS,
    parameter int   P_GUARD_CYCLES = 16,
    parameter int   P_GUARD_W      = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_req_valid,
    output logic       o_req_ready,
    input  logic [7:0] i_req_dest,
    output logic [5:0] o_grant,
    output logic       o_path_en,
    output logic       o_cfg_done,
    output logic       o_cfg_err,
    output logic [7:0] o_active_dest,
    output logic       o_busy
);

    localparam logic [P_GUARD_W-1:0] GUARD_LOAD = P_GUARD_W'(P_GUARD_CYCLES - 1);

    ocs_state_e           state, state_nxt;
    logic [7:0]           dest_q;
    logic [5:0]           code_q;
    logic [P_GUARD_W-1:0] guard_cnt;
    logic                 err_q;
    logic                 active_valid;
    logic [7:0]           route_dest;
    logic                 match;
    logic                 legal;
    logic                 same_map;

    ocs_4x4_route_model #(.P_BAR(P_BAR), .P_CROSS(P_CROSS)) u_route (
        .code (code_q),
        .dest (route_dest)
    );

    assign match    = (route_dest == dest_q);
    assign legal    = perm_legal(dest_q);
    assign same_map = active_valid && (dest_q == o_active_dest);

    assign o_req_ready = (state == ST_IDLE);
    assign o_busy      = (state != ST_IDLE);
    assign o_cfg_done  = (state == ST_DONE);
    assign o_cfg_err   = (state == ST_DONE) && err_q;

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next-state selection.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (i_req_valid) state_nxt = ST_CHECK;
            ST_CHECK:  state_nxt = (!legal || same_map) ? ST_DONE : ST_SEARCH;
            ST_SEARCH: if (match) state_nxt = ST_GUARD;
                       else if (code_q == LAST_CODE) state_nxt = ST_DONE;
            ST_GUARD:  if (guard_cnt == '0) state_nxt = ST_DONE;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: request latch, code search, fabric outputs and guard timer.
    // The grant register is written only on a verified match, so it never
    // carries a code that was tried and rejected.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            dest_q        <= '0;
            code_q        <= '0;
            guard_cnt     <= '0;
            err_q         <= 1'b0;
            active_valid  <= 1'b0;
            o_grant       <= 6'h00;
            o_path_en     <= 1'b0;
            o_active_dest <= IDENTITY_MAP;
        end else begin
            case (state)
                ST_IDLE: if (i_req_valid) begin
                    dest_q <= i_req_dest;
                    err_q  <= 1'b0;
                end
                ST_CHECK: begin
                    code_q <= '0;
                    err_q  <= !legal;
                end
                ST_SEARCH: begin
                    if (match) begin
                        o_grant       <= code_q;
                        o_path_en     <= 1'b0;
                        o_active_dest <= dest_q;
                        active_valid  <= 1'b1;
                        guard_cnt     <= GUARD_LOAD;
                    end else if (code_q == LAST_CODE) begin
                        err_q <= 1'b1;
                    end else begin
                        code_q <= code_q + 6'd1;
                    end
                end
                ST_GUARD: begin
                    if (guard_cnt == '0) o_path_en <= 1'b1;
                    else                 guard_cnt <= guard_cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ocs_4x4_cfg_ctrl.sv
// Self-checking bench for ocs_4x4_cfg_ctrl with an expected-result queue.
module tb_ocs_4x4_cfg_ctrl;

    localparam int G = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic [7:0] req_dest;
    logic       req_ready;
    logic [5:0] grant;
    logic       path_en;
    logic       cfg_done;
    logic       cfg_err;
    logic [7:0] active_dest;
    logic       busy;

    int checks = 0;
    int passed = 0;

    typedef struct {
        logic [7:0] dest;
        logic       err;
        logic [5:0] grant;
        logic [7:0] active;
        logic       path;
        int         lat;
        int         gchg;
        bit         searched;
    } exp_t;

    exp_t sb[$];

    logic [5:0] m_grant  = 6'h00;
    logic [7:0] m_active = 8'hE4;
    logic       m_valid  = 1'b0;
    logic       m_path   = 1'b0;

    ocs_4x4_cfg_ctrl #(.P_GUARD_CYCLES(G)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_req_valid   (req_valid),
        .o_req_ready   (req_ready),
        .i_req_dest    (req_dest),
        .o_grant       (grant),
        .o_path_en     (path_en),
        .o_cfg_done    (cfg_done),
        .o_cfg_err     (cfg_err),
        .o_active_dest (active_dest),
        .o_busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Fabric reference: track which input port label sits on each wire.
    function automatic void sw(input logic g, input int in1, input int in0,
                               output int out1, output int out0);
        if (g) begin out0 = in1; out1 = in0; end
        else   begin out0 = in0; out1 = in1; end
    endfunction

    function automatic logic [7:0] ref_route(input logic [5:0] c);
        int a0, a1, b0, b1, c0, c1, d0, d1, f0, f1, h0, h1;
        int src [4];
        logic [7:0] r;
        sw(c[3], 3,  2,  d1, d0);
        sw(c[1], d0, 1,  b1, b0);
        sw(c[0], b0, 0,  a1, a0);
        sw(c[4], d1, b1, f1, f0);
        sw(c[2], f0, a1, c1, c0);
        sw(c[5], f1, c1, h1, h0);
        src[0] = a0; src[1] = c0; src[2] = h0; src[3] = h1;
        r = '0;
        for (int o = 0; o < 4; o++) r[2*src[o] +: 2] = 2'(o);
        return r;
    endfunction

    function automatic int find_code(input logic [7:0] d);
        for (int c = 0; c < 64; c++)
            if (ref_route(6'(c)) == d) return c;
        return -1;
    endfunction

    function automatic bit distinct(input logic [7:0] d);
        bit seen [4];
        for (int i = 0; i < 4; i++) seen[i] = 0;
        for (int i = 0; i < 4; i++) begin
            if (seen[d[2*i +: 2]]) return 0;
            seen[d[2*i +: 2]] = 1;
        end
        return 1;
    endfunction

    // Issue one request, queue its expected outcome, then compare on completion.
    task automatic do_req(input logic [7:0] d);
        exp_t e;
        int   k, cyc, chg;
        logic prev_path;
        logic [5:0] prev_g;
        e.dest = d; e.err = 1'b0; e.grant = m_grant; e.active = m_active;
        e.path = m_path; e.lat = 2; e.gchg = -1; e.searched = 0;
        if (!distinct(d)) begin
            e.err = 1'b1;
        end else if (m_valid && d == m_active) begin
            e.err = 1'b0;
        end else begin
            k = find_code(d);
            if (k < 0) begin
                e.err = 1'b1; e.lat = 66;
            end else begin
                e.grant = 6'(k); e.active = d; e.path = 1'b1; e.lat = 3 + k + G;
                e.gchg = (6'(k) != m_grant) ? 3 + k : -1; e.searched = 1;
                m_grant = 6'(k); m_active = d; m_valid = 1'b1; m_path = 1'b1;
            end
        end
        sb.push_back(e);

        checks++;
        if (req_ready !== 1'b1) $display("FAIL ready_idle dest=%h got=%b want=1", d, req_ready);
        else passed++;
        req_valid = 1'b1; req_dest = d;
        prev_g = grant; chg = -1; prev_path = path_en;
        step();
        req_valid = 1'b0;
        cyc = 1;
        while (cyc < 200 && cfg_done !== 1'b1) begin
            if (grant !== prev_g && chg < 0) chg = cyc;
            prev_path = path_en;
            step();
            cyc++;
        end
        if (grant !== prev_g && chg < 0) chg = cyc;
        e = sb.pop_front();
        checks++;
        if (cfg_done !== 1'b1) begin
            $display("FAIL done_timeout dest=%h waited=%0d cycles", d, cyc);
            step();
            return;
        end
        passed++;
        checks++;
        if (cyc != e.lat) $display("FAIL latency dest=%h got=%0d want=%0d", d, cyc, e.lat);
        else passed++;
        checks++;
        if (cfg_err !== e.err) $display("FAIL err dest=%h got=%b want=%b", d, cfg_err, e.err);
        else passed++;
        checks++;
        if (grant !== e.grant) $display("FAIL grant dest=%h got=%h want=%h", d, grant, e.grant);
        else passed++;
        checks++;
        if (active_dest !== e.active)
            $display("FAIL active dest=%h got=%h want=%h", d, active_dest, e.active);
        else passed++;
        checks++;
        if (path_en !== e.path) $display("FAIL path_en dest=%h got=%b want=%b", d, path_en, e.path);
        else passed++;
        checks++;
        if (chg != e.gchg) $display("FAIL grant_time dest=%h got=%0d want=%0d", d, chg, e.gchg);
        else passed++;
        if (e.searched) begin
            checks++;
            if (prev_path !== 1'b0)
                $display("FAIL guard_blank dest=%h got=%b want=0", d, prev_path);
            else passed++;
            checks++;
            if (ref_route(grant) !== d)
                $display("FAIL route_of_grant dest=%h got=%h", d, ref_route(grant));
            else passed++;
        end
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; req_dest = '0;
        repeat (3) step();
        rst = 1'b0;
        checks++;
        if ({grant, path_en, cfg_done, cfg_err, active_dest, busy, req_ready} !==
            {6'h00, 1'b0, 1'b0, 1'b0, 8'hE4, 1'b0, 1'b1})
            $display("FAIL reset_vals got grant=%h pe=%b done=%b err=%b act=%h busy=%b rdy=%b",
                     grant, path_en, cfg_done, cfg_err, active_dest, busy, req_ready);
        else passed++;
        step();
    endtask

    task automatic test_identity();
        do_req(8'hE4);
    endtask

    task automatic test_swap_23();
        do_req(8'hB4);
        checks++;
        if (grant !== 6'h08) $display("FAIL b4_grant got=%h want=08", grant);
        else passed++;
    endtask

    task automatic test_same_map();
        do_req(8'hB4);
    endtask

    task automatic test_reject();
        do_req(8'h00);
    endtask

    task automatic test_mid_reset();
        int k;
        k = find_code(8'h1B);
        checks++;
        if (k < 0) begin
            $display("FAIL mid_reset_code got=none want=reachable");
            return;
        end
        passed++;
        req_valid = 1'b1; req_dest = 8'h1B;
        step();
        req_valid = 1'b0;
        step();
        req_valid = 1'b1; req_dest = 8'h4E;
        checks++;
        if (req_ready !== 1'b0) $display("FAIL ready_search got=%b want=0", req_ready);
        else passed++;
        step();
        req_valid = 1'b0;
        for (int c = 3; c < 7 + k; c++) step();
        checks++;
        if (busy !== 1'b1 || path_en !== 1'b0 || grant !== 6'(k))
            $display("FAIL in_guard got busy=%b pe=%b grant=%h want 1 0 %h", busy, path_en, grant, 6'(k));
        else passed++;
        rst = 1'b1;
        step();
        rst = 1'b0;
        m_grant = 6'h00; m_active = 8'hE4; m_valid = 1'b0; m_path = 1'b0;
        checks++;
        if ({grant, path_en, cfg_done, cfg_err, active_dest, busy, req_ready} !==
            {6'h00, 1'b0, 1'b0, 1'b0, 8'hE4, 1'b0, 1'b1})
            $display("FAIL post_reset got grant=%h pe=%b done=%b err=%b act=%h busy=%b rdy=%b",
                     grant, path_en, cfg_done, cfg_err, active_dest, busy, req_ready);
        else passed++;
        begin
            bit seen_done;
            seen_done = 0;
            repeat (90) begin
                step();
                if (cfg_done === 1'b1 || busy === 1'b1) seen_done = 1;
            end
            checks++;
            if (seen_done) $display("FAIL ignored_req got=activity want=idle");
            else passed++;
        end
    endtask

    task automatic test_sweep();
        for (int a = 0; a < 4; a++)
            for (int b = 0; b < 4; b++)
                for (int c = 0; c < 4; c++)
                    for (int d = 0; d < 4; d++)
                        if (a != b && a != c && a != d && b != c && b != d && c != d)
                            do_req({2'(d), 2'(c), 2'(b), 2'(a)});
    endtask

    initial begin
        test_reset();
        test_identity();
        test_swap_23();
        test_same_map();
        test_reject();
        test_mid_reset();
        test_sweep();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
